// File: rtl/minibus_arbiter_rr.sv
// minibus_arbiter_rr: round-robin arbiter of N_CH requesters onto one
// minibus master port, registered grant, one transaction in flight.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ch_req/wen/addr/wdata/width  per-channel request bundle (packed)
//   ch_ack/ch_err             one-cycle completion pulse and status
//   ch_rdata                  shared load data, held between acks
//   mb_addr/wdata/width/wen/ren  minibus request, stable while BUSY
//   mb_ack/mb_err/mb_rdata    minibus completion from the slave
//
// Build option: define MINIBUS_ARB_TIMEOUT_EN to abort a BUSY phase
// after TIMEOUT_CYC cycles without mb_ack (ack with error, data 0).
module minibus_arbiter_rr #(
  parameter int N_CH        = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          ch_req,
  input  logic [N_CH-1:0]          ch_wen,
  input  logic [N_CH*ADDR_W-1:0]   ch_addr,
  input  logic [N_CH*DATA_W-1:0]   ch_wdata,
  input  logic [N_CH*2-1:0]        ch_width,
  output logic [N_CH-1:0]          ch_ack,
  output logic [N_CH-1:0]          ch_err,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [ADDR_W-1:0]        mb_addr,
  output logic [DATA_W-1:0]        mb_wdata,
  output logic [1:0]               mb_width,
  output logic                     mb_wen,
  output logic                     mb_ren,
  input  logic                     mb_ack,
  input  logic                     mb_err,
  input  logic [DATA_W-1:0]        mb_rdata
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

  if (N_CH < 1) begin : g_bad_nch
    $error("minibus_arbiter_rr: N_CH must be >= 1");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_tmo
    $error("minibus_arbiter_rr: TIMEOUT_CYC must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       rr_q;
  logic [PW-1:0]       gnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [1:0]          width_q;
  logic                wen_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [PW-1:0]       pick;
  logic [PW-1:0]       idx;
  logic                found;
  logic                bad_w;
  logic                tmo_hit;

  // Search starts one past the last winner and wraps, so the
  // previous winner is the last candidate considered.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = rr_q;
    for (int i = 0; i < N_CH; i++) begin
      idx = (idx == PW'(N_CH - 1)) ? '0 : idx + 1'b1;
      if (!found && ch_req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign bad_w = (ch_width[pick*2 +: 2] == 2'b11);

`ifdef MINIBUS_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ?
                      $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CW-1:0] cnt_q;

  // Zero outside BUSY, so every BUSY phase starts counting from 0.
  always_ff @(posedge clk) begin
    if (rst || state_q != BUSY) begin
      cnt_q <= '0;
    end else if (!mb_ack) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tmo_hit = (state_q == BUSY) && !mb_ack &&
                   (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = bad_w ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (mb_ack || tmo_hit) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= PW'(N_CH - 1);
      gnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && found) begin
        gnt_q   <= pick;
        rr_q    <= pick;
        addr_q  <= ch_addr[pick*ADDR_W +: ADDR_W];
        wdata_q <= ch_wdata[pick*DATA_W +: DATA_W];
        width_q <= ch_width[pick*2 +: 2];
        wen_q   <= ch_wen[pick];
        err_q   <= bad_w;
        if (bad_w) begin
          rdata_q <= '0;
        end
      end
      if (state_q == BUSY) begin
        if (mb_ack) begin
          err_q   <= mb_err;
          rdata_q <= wen_q ? '0 : mb_rdata;
        end else if (tmo_hit) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
      end
    end
  end

  always_comb begin
    ch_ack = '0;
    ch_err = '0;
    if (state_q == RESP) begin
      ch_ack[gnt_q] = 1'b1;
      ch_err[gnt_q] = err_q;
    end
  end

  assign ch_rdata = rdata_q;
  assign mb_addr  = addr_q;
  assign mb_wdata = wdata_q;
  assign mb_width = width_q;
  assign mb_wen   = (state_q == BUSY) && wen_q;
  assign mb_ren   = (state_q == BUSY) && !wen_q;

endmodule

// File: tb/tb_minibus_arbiter_rr.sv
// tb_minibus_arbiter_rr: directed bench for minibus_arbiter_rr,
// two channels, TIMEOUT_CYC=4.
module tb_minibus_arbiter_rr;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    ch_req;
  logic [N-1:0]    ch_wen;
  logic [N*AW-1:0] ch_addr;
  logic [N*DW-1:0] ch_wdata;
  logic [N*2-1:0]  ch_width;
  logic [N-1:0]    ch_ack;
  logic [N-1:0]    ch_err;
  logic [DW-1:0]   ch_rdata;
  logic [AW-1:0]   mb_addr;
  logic [DW-1:0]   mb_wdata;
  logic [1:0]      mb_width;
  logic            mb_wen;
  logic            mb_ren;
  logic            mb_ack;
  logic            mb_err;
  logic [DW-1:0]   mb_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  minibus_arbiter_rr #(
    .N_CH(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(4)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_req(ch_req), .ch_wen(ch_wen),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_width(ch_width),
    .ch_ack(ch_ack), .ch_err(ch_err),
    .ch_rdata(ch_rdata),
    .mb_addr(mb_addr), .mb_wdata(mb_wdata),
    .mb_width(mb_width),
    .mb_wen(mb_wen), .mb_ren(mb_ren),
    .mb_ack(mb_ack), .mb_err(mb_err),
    .mb_rdata(mb_rdata)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1, "watchdog");
  end

  int order[$];
  int multi;

  initial begin
    rst = 1'b1;
    ch_req = '0; ch_wen = '0;
    ch_addr = '0; ch_wdata = '0; ch_width = '0;
    mb_ack = 1'b0; mb_err = 1'b0; mb_rdata = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_ack", 64'(ch_ack), 0);
    chk("rst_ren", 64'(mb_ren), 0);
    chk("rst_wen", 64'(mb_wen), 0);
    chk("rst_addr", 64'(mb_addr), 0);
    chk("rst_rdata", 64'(ch_rdata), 0);

    // single load on ch0, zero-wait slave
    ch_addr[0 +: AW] = 32'h100;
    ch_width[0 +: 2] = 2'b10;
    ch_req = 2'b01;
    step();
    chk("ld_ren", 64'(mb_ren), 1);
    chk("ld_wen", 64'(mb_wen), 0);
    chk("ld_addr", 64'(mb_addr), 64'h100);
    chk("ld_width", 64'(mb_width), 2);
    mb_ack = 1'b1; mb_rdata = 32'hDEADBEEF;
    step();
    chk("ld_ack", 64'(ch_ack), 1);
    chk("ld_err", 64'(ch_err), 0);
    chk("ld_rdata", 64'(ch_rdata), 64'hDEADBEEF);
    chk("ld_ren_drop", 64'(mb_ren), 0);
    mb_ack = 1'b0; ch_req = '0;
    step();
    chk("ld_ack_gone", 64'(ch_ack), 0);
    chk("ld_rdata_hold", 64'(ch_rdata), 64'hDEADBEEF);

    // store on ch1, slave waits 3 cycles
    ch_wen[1] = 1'b1;
    ch_addr[AW +: AW] = 32'h2004;
    ch_wdata[DW +: DW] = 32'hA5;
    ch_width[2 +: 2] = 2'b00;
    ch_req = 2'b10;
    step();
    ch_addr[AW +: AW] = 32'hFFFF;
    ch_wdata[DW +: DW] = 32'h77;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("st_wen%0d", k), 64'(mb_wen), 1);
      chk($sformatf("st_ack%0d", k), 64'(ch_ack), 0);
      if (k == 3) begin
        chk("st_addr", 64'(mb_addr), 64'h2004);
        chk("st_wdata", 64'(mb_wdata), 64'hA5);
        chk("st_width", 64'(mb_width), 0);
        chk("st_ren", 64'(mb_ren), 0);
        mb_ack = 1'b1;
        mb_rdata = 32'h5555;
      end
      step();
    end
    chk("st_ack", 64'(ch_ack), 2);
    chk("st_err", 64'(ch_err), 0);
    chk("st_rdata", 64'(ch_rdata), 0);
    chk("st_wen_drop", 64'(mb_wen), 0);
    mb_ack = 1'b0; ch_req = '0; ch_wen = '0;
    step();

    // contention, slave acks constantly
    ch_addr[0 +: AW] = 32'h10;
    ch_addr[AW +: AW] = 32'h20;
    ch_width = 4'b1010;
    mb_ack = 1'b1; mb_rdata = 32'h1234;
    ch_req = 2'b11;
    multi = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (ch_ack == 2'b11) multi++;
      if (ch_ack == 2'b01) order.push_back(0);
      if (ch_ack == 2'b10) order.push_back(1);
    end
    ch_req = '0; mb_ack = 1'b0;
    chk("rr_multi", 64'(multi), 0);
    chk("rr_count", 64'(order.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < order.size())
        chk($sformatf("rr_order%0d", i), 64'(order[i]), 64'(i % 2));
    end
    chk("rr_rdata", 64'(ch_rdata), 64'h1234);
    step();

    // illegal width on ch0: no bus access
    ch_width[0 +: 2] = 2'b11;
    ch_req = 2'b01;
    step();
    chk("ill_ren", 64'(mb_ren), 0);
    chk("ill_wen", 64'(mb_wen), 0);
    chk("ill_ack", 64'(ch_ack), 1);
    chk("ill_err", 64'(ch_err), 1);
    chk("ill_rdata", 64'(ch_rdata), 0);
    ch_req = '0; ch_width[0 +: 2] = 2'b10;
    step();

    // slave error on ch1
    ch_req = 2'b10;
    step();
    chk("berr_ren", 64'(mb_ren), 1);
    chk("berr_addr", 64'(mb_addr), 64'h20);
    mb_ack = 1'b1; mb_err = 1'b1;
    step();
    chk("berr_ack", 64'(ch_ack), 2);
    chk("berr_err", 64'(ch_err), 2);
    mb_ack = 1'b0; mb_err = 1'b0; ch_req = '0;
    step();

    // slave never acks on ch0
    ch_req = 2'b01;
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to_ren%0d", k), 64'(mb_ren), 1);
      step();
    end
`ifdef MINIBUS_ARB_TIMEOUT_EN
    chk("to_ren_drop", 64'(mb_ren), 0);
    chk("to_ack", 64'(ch_ack), 1);
    chk("to_err", 64'(ch_err), 1);
    chk("to_rdata", 64'(ch_rdata), 0);
    ch_req = '0;
    step();
    mb_ack = 1'b1; mb_rdata = 32'h9999;
    step();
    chk("late_ack", 64'(ch_ack), 0);
    chk("late_rdata", 64'(ch_rdata), 0);
    mb_ack = 1'b0;
    ch_req = 2'b01;
    step();
    chk("to_rebusy", 64'(mb_ren), 1);
`else
    chk("nto_ren", 64'(mb_ren), 1);
    chk("nto_ack", 64'(ch_ack), 0);
`endif

    // reset while BUSY on ch0; ch0 is the last winner
    ch_req = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_ren", 64'(mb_ren), 0);
    chk("mrst_ack", 64'(ch_ack), 0);
    step();
    chk("mrst_noack", 64'(ch_ack), 0);
    ch_req = 2'b11;
    step();
    chk("mrst_addr", 64'(mb_addr), 64'h10);
    mb_ack = 1'b1; mb_rdata = 32'h42;
    step();
    chk("mrst_gnt", 64'(ch_ack), 1);
    chk("mrst_rdata", 64'(ch_rdata), 64'h42);
    mb_ack = 1'b0; ch_req = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
